// File: rtl/turn_scheduler.sv
// Turn scheduler: sequences manual/automatic player attacks, board checks
// and game-over for a multi-player board game.
// Ports: clk, rst (async, active-high); start, first_player, auto_mask,
//   alive, attack_done, gameover in; en_attack, en_auto, en_check,
//   cur_player, timer, turn_count, done, state_o out.
module turn_scheduler #(
  parameter  int NUM_PLAYERS    = 2,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PW-1:0]          first_player,
  input  logic [NUM_PLAYERS-1:0] auto_mask,
  input  logic [NUM_PLAYERS-1:0] alive,
  input  logic                   attack_done,
  input  logic                   gameover,
  output logic [NUM_PLAYERS-1:0] en_attack,
  output logic                   en_auto,
  output logic                   en_check,
  output logic [PW-1:0]          cur_player,
  output logic [TW-1:0]          timer,
  output logic [15:0]            turn_count,
  output logic                   done,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ATTACK = 3'd1,
    AUTO   = 3'd2,
    CHECK  = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t                   state, state_n;
  logic [NUM_PLAYERS-1:0]   auto_q;
  logic [PW-1:0]            fp_c;
  logic [PW-1:0]            nxt;
  logic [PW-1:0]            cand;
  logic                     found;

  // Out-of-range starting player falls back to player 0.
  assign fp_c = (int'(first_player) < NUM_PLAYERS) ? first_player : '0;

  // First live player after cur_player, wrapping; keeps cur if none.
  always_comb begin
    nxt   = cur_player;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      cand = PW'((int'(cur_player) + k) % NUM_PLAYERS);
      if (!found && alive[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start)
          state_n = auto_mask[fp_c] ? AUTO : ATTACK;
      ATTACK:
        if (attack_done)           state_n = CHECK;
        else if (timer == TW'(1))  state_n = AUTO;
      AUTO:
        if (attack_done) state_n = CHECK;
      CHECK:
        if (gameover) state_n = OVER;
        else          state_n = auto_q[nxt] ? AUTO : ATTACK;
      OVER:    state_n = OVER;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_player <= '0;
      timer      <= '0;
      turn_count <= '0;
      auto_q     <= '0;
    end else begin
      if (state == IDLE && start) begin
        auto_q     <= auto_mask;
        cur_player <= fp_c;
      end
      if (state == CHECK) begin
        if (turn_count != 16'hFFFF)
          turn_count <= turn_count + 16'd1;
        if (!gameover)
          cur_player <= nxt;
      end
      // Reload on entry to ATTACK, count down while in it, else 0.
      if (state_n == ATTACK && state != ATTACK)
        timer <= TW'(TIMEOUT_CYCLES);
      else if (state == ATTACK && state_n == ATTACK)
        timer <= timer - TW'(1);
      else
        timer <= '0;
    end
  end

  always_comb begin
    en_attack = '0;
    en_attack[cur_player] = (state == ATTACK);
    en_auto  = (state == AUTO);
    en_check = (state == CHECK);
    done     = (state == OVER);
    state_o  = state;
  end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter NUM_PLAYERS, 2, number of players; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, 1000, cycles a manual player has to finish an attack; minimum 1.
REQ-003 Derived widths: PW = max(1, clog2(NUM_PLAYERS)); TW = clog2(TIMEOUT_CYCLES+1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  pulse; leaves IDLE and begins the game.
REQ-007 first_player  input  PW  starting player index, sampled with start.
REQ-008 auto_mask  input  NUM_PLAYERS  bit i=1 means player i attacks automatically, sampled with start.
REQ-009 alive  input  NUM_PLAYERS  live-player mask, read combinationally when selecting the next player.
REQ-010 attack_done  input  1  one-cycle pulse: the current attack has completed.
REQ-011 gameover  input  1  game-end flag from the checker, sampled only in CHECK.
REQ-012 en_attack  output  NUM_PLAYERS  one-hot manual-attack enable for cur_player.
REQ-013 en_auto  output  1  automatic/random attack enable for cur_player.
REQ-014 en_check  output  1  board-check enable.
REQ-015 cur_player  output  PW  index of the active player.
REQ-016 timer  output  TW  cycles remaining in the current manual turn.
REQ-017 turn_count  output  16  completed turns, saturating at 16'hFFFF.
REQ-018 done  output  1  high in OVER; cur_player then names the winner.
REQ-019 state_o  output  3  encoded state: IDLE=0, ATTACK=1, AUTO=2, CHECK=3, OVER=4.

Function
REQ-020 States IDLE, ATTACK, AUTO, CHECK, OVER; outputs are Moore (decoded from registered state only).
REQ-021 IDLE: on start, latch auto_mask and cur_player <= first_player; next state is AUTO if the latched auto bit for that player is set, else ATTACK.
REQ-022 A first_player value >= NUM_PLAYERS is clamped to 0.
REQ-023 Entering ATTACK loads timer <= TIMEOUT_CYCLES; each ATTACK cycle without attack_done decrements timer by 1.
REQ-024 ATTACK: attack_done -> CHECK; else timer==1 -> AUTO (timeout takeover); else stay.
REQ-025 When attack_done and timeout coincide in one cycle, attack_done wins and the next state is CHECK.
REQ-026 AUTO: attack_done -> CHECK; else stay; timer holds 0 in AUTO.
REQ-027 CHECK lasts exactly one cycle; turn_count increments on exit (saturating).
REQ-028 CHECK with gameover=1 -> OVER; cur_player is held.
REQ-029 CHECK with gameover=0: cur_player <= the next index with alive=1, searching cur+1, cur+2, ... modulo NUM_PLAYERS; if none other is alive, cur_player is kept.
REQ-030 After CHECK, the next state is AUTO if the latched auto bit for the new player is set, else ATTACK.
REQ-031 en_attack[cur_player]=1 only in ATTACK; en_auto=1 only in AUTO; en_check=1 only in CHECK; done=1 only in OVER.
REQ-032 OVER is absorbing; only rst exits it.
REQ-033 start outside IDLE and attack_done outside ATTACK/AUTO are ignored.

Reset
REQ-034 rst asserted at any time (including mid-turn) forces IDLE immediately, with every output 0.
REQ-035 rst clears cur_player, timer, turn_count and the latched auto_mask to 0.

Verification
REQ-036 NUM_PLAYERS=2, TIMEOUT_CYCLES=5, start with first_player=1, auto_mask=0 -> ATTACK, en_attack=2'b10, timer=5; attack_done at timer=3 -> CHECK for 1 cycle -> ATTACK with cur_player=0 and turn_count=1.
REQ-037 TIMEOUT_CYCLES=5, no attack_done -> timer counts 5,4,3,2,1, then AUTO with en_auto=1; attack_done -> CHECK.
REQ-038 attack_done in the same cycle that timer==1 -> CHECK, never AUTO.
REQ-039 NUM_PLAYERS=4, cur_player=1, alive=4'b1001, gameover=0 in CHECK -> cur_player=3; from 3 with the same mask -> 0.
REQ-040 auto_mask=2'b01, first_player=0 -> AUTO directly; gameover=1 in CHECK -> OVER, done=1, cur_player=0; start ignored thereafter.
REQ-041 rst pulsed mid-ATTACK with timer=2 -> state_o=0 and all outputs 0 asynchronously; next start restarts cleanly.
